bounce_gen: RTL and testbench

- Synthesizable contact-bounce emulator: the transmitter side of the glitch-filter path.
- Takes a clean, synchronous level `sig_in` and drives `sigout`. After every level change, `sigout` bounces for a programmable number of cycles, then settles to the new level.
- Sits ahead of the `filter` block in board-level self-test and loopback benches, so the filter sees realistic, repeatable bounce.

---
 rtl/bounce_gen.sv | 82 ++++++++
 tb/tb_bounce_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: after each sig_in level change, sigout bounces for BOUNCE_LEN cycles then settles.
// Define BOUNCE_GEN_LFSR_EN for pseudo-random bounce bits; otherwise the output toggles each bounce cycle.
module bounce_gen #(
  parameter int unsigned BOUNCE_LEN  = 16,
  parameter int unsigned CNT_W       = 5,
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter logic        RESET_LEVEL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic sigout,
  output logic busy
);

  typedef enum logic {IDLE, BOUNCE} state_e;

  localparam logic [7:0]       SEED_FIX = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(BOUNCE_LEN - 1);

  state_e           state_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_d;
  logic             sigout_q;
  logic             busy_q;
  logic             trig;
  logic             bounce_bit;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    trig   = (sig_in != level_q);
`ifdef BOUNCE_GEN_LFSR_EN
    bounce_bit = lfsr_q[0];
`else
    bounce_bit = ~sigout_q;
`endif
  end

  // A trigger overrides everything, including the final cnt==0 cycle, so a window only ever restarts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      level_q  <= RESET_LEVEL;
      cnt_q    <= '0;
      lfsr_q   <= SEED_FIX;
      sigout_q <= RESET_LEVEL;
      busy_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      if (trig) begin
        level_q  <= sig_in;
        cnt_q    <= RELOAD;
        state_q  <= BOUNCE;
        busy_q   <= 1'b1;
        sigout_q <= bounce_bit;
      end else begin
        case (state_q)
          BOUNCE: begin
            if (cnt_q == '0) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              sigout_q <= level_q;
            end else begin
              cnt_q    <= cnt_q - CNT_W'(1);
              sigout_q <= bounce_bit;
            end
          end
          default: begin
            sigout_q <= level_q;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sigout = sigout_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: reset, single edge, retrigger, trigger-at-window-end, LFSR sequence, mid-window reset.
module tb_bounce_gen;

  logic clock;
  logic reset;
  logic sig4, sig16, sigz;
  logic so4, so16, soz;
  logic b4, b16, bz;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] m16, m16_prev, mz;

  bit e1s [0:6] = '{0, 1, 0, 1, 0, 0, 0};
  bit e1b [0:6] = '{1, 1, 1, 1, 0, 0, 0};
  bit e2s [0:7] = '{0, 1, 0, 1, 0, 1, 1, 1};
  bit e2b [0:7] = '{1, 1, 1, 1, 1, 1, 0, 0};
  bit e3s [0:8] = '{0, 1, 0, 1, 0, 1, 0, 1, 1};
  bit e3b [0:8] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

  bounce_gen #(.BOUNCE_LEN(4), .CNT_W(5), .SEED(8'hA5), .RESET_LEVEL(1'b1)) dut4 (
    .clock(clock), .reset(reset), .sig_in(sig4), .sigout(so4), .busy(b4));
  bounce_gen #(.BOUNCE_LEN(16), .CNT_W(5), .SEED(8'hA5), .RESET_LEVEL(1'b1)) dut16 (
    .clock(clock), .reset(reset), .sig_in(sig16), .sigout(so16), .busy(b16));
  bounce_gen #(.BOUNCE_LEN(16), .CNT_W(5), .SEED(8'h00), .RESET_LEVEL(1'b1)) dutz (
    .clock(clock), .reset(reset), .sig_in(sigz), .sigout(soz), .busy(bz));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] nx(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSRs; m16_prev holds the value the DUT used on the most recent edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m16 <= 8'hA5;
      mz  <= 8'h01;
    end else begin
      m16_prev <= m16;
      m16      <= nx(m16);
      mz       <= nx(mz);
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    sig4  = 1'b1;
    sig16 = 1'b1;
    sigz  = 1'b1;
    #100;
    chk("rst_sigout4", {7'd0, so4}, 8'd1);
    chk("rst_busy4", {7'd0, b4}, 8'd0);
    chk("rst_sigout16", {7'd0, so16}, 8'd1);
    chk("rst_lfsr16", dut16.lfsr_q, 8'hA5);
    chk("rst_lfsr_seed0", dutz.lfsr_q, 8'h01);
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_sigout4", {7'd0, so4}, 8'd1);
      chk("idle_busy4", {7'd0, b4}, 8'd0);
      chk("idle_busy16", {7'd0, b16}, 8'd0);
      chk("idle_lfsr16", dut16.lfsr_q, m16);
      chk("idle_lfsr_seed0", dutz.lfsr_q, mz);
    end

    sig4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("single_sigout", {7'd0, so4}, {7'd0, e1s[i]});
      chk("single_busy", {7'd0, b4}, {7'd0, e1b[i]});
    end

    sig4 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("settle_high", {7'd0, so4}, 8'd1);
    sig4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) sig4 = 1'b1;
      tick();
      chk("retrig_sigout", {7'd0, so4}, {7'd0, e2s[i]});
      chk("retrig_busy", {7'd0, b4}, {7'd0, e2b[i]});
    end

    sig4 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) sig4 = 1'b1;
      tick();
      chk("endwin_sigout", {7'd0, so4}, {7'd0, e3s[i]});
      chk("endwin_busy", {7'd0, b4}, {7'd0, e3b[i]});
    end

    sig16 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      logic expb;
      tick();
`ifdef BOUNCE_GEN_LFSR_EN
      expb = m16_prev[0];
`else
      expb = (j % 2 == 1);
`endif
      chk("len16_sigout", {7'd0, so16}, {7'd0, expb});
      chk("len16_busy", {7'd0, b16}, 8'd1);
    end
    tick();
    chk("len16_settled", {7'd0, so16}, 8'd0);
    chk("len16_busy_end", {7'd0, b16}, 8'd0);

    for (int n = 0; n < 300; n++) begin
      tick();
      checks++;
      assert (dut16.lfsr_q !== 8'h00) else begin
        errors++;
        $error("FAIL lfsr_nonzero: observed %0h expected nonzero", dut16.lfsr_q);
      end
      chk("lfsr16_seq", dut16.lfsr_q, nx(m16_prev));
      chk("lfsr_seed0_seq", dutz.lfsr_q, mz);
    end

    sig4 = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_pre_sigout", {7'd0, so4}, 8'd0);
    chk("mid_pre_busy", {7'd0, b4}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_sigout", {7'd0, so4}, 8'd1);
    chk("mid_rst_busy", {7'd0, b4}, 8'd0);
    chk("mid_rst_lfsr16", dut16.lfsr_q, 8'hA5);
    chk("mid_rst_lfsr_seed0", dutz.lfsr_q, 8'h01);
    sig4  = 1'b1;
    sig16 = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_sigout", {7'd0, so4}, 8'd1);
      chk("post_rst_busy", {7'd0, b4}, 8'd0);
      chk("post_rst_lfsr_seed0", dutz.lfsr_q, mz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
